rv32i_dmem_responder: RTL and testbench
=======================================

# rv32i_dmem_responder

Data-side memory responder for the RV32I pipelined CPU: it receives the CPU's word-wide data-memory requests and answers reads in the same cycle. It sits between the CPU's data port and the system. It decodes each address into one of two regions:
- a word RAM;
- a small memory-mapped I/O bank: free-running cycle counter, compare timer, LED register, and a byte transmit FIFO with a valid/ready output handshake.

## Interface
Parameters:
- RAM_WORDS, 1024: RAM depth in 32-bit words (power of 2).
- LED_WIDTH, 8: width of led output.
- TXFIFO_DEPTH, 8: TX FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- Memwrite  in  1  write strobe from CPU.
- Memaddr  in  32  byte address from CPU (bits [1:0] ignored).
- MemWdata  in  32  write data from CPU.
- MemRdata  out  32  read data to CPU, combinational from Memaddr.
- led  out  LED_WIDTH  LED register contents.
- tx_valid  out  1  TX FIFO head valid.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  consumer accepts head this cycle.

Clocking and reset: one clock, clk; reset is synchronous and active-high.

## Operation
- **RAM region**
  - Selected when Memaddr[31:28]==4'h1.
  - Word index is Memaddr[log2(RAM_WORDS)+1:2]; upper bits are aliased.
- **IO region**
  - Selected when Memaddr[31:8]==24'hFFFF00. Register offsets (Memaddr[7:0]):
  - 0x00 CYCLE, read-only: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0. Writes are ignored.
  - 0x04 TCMP, read/write: compare value.
  - 0x08 TSTAT, read/write-1-to-clear: bit0 MATCH sets on any cycle where CYCLE==TCMP.
  - 0x0C LED, read/write: bits [LED_WIDTH-1:0] are stored; upper bits read 0.
  - 0x10 TXDATA, write-only: pushes MemWdata[7:0]. Reads return 0.
  - 0x14 TXSTAT:
    - bit0 FULL, bit1 EMPTY, bit2 OVF (sticky, write-1-to-clear), bits[15:8] count.
    - All other bits read 0.
- **Unmapped accesses**: any other address reads 0x00000000, and writes to it have no effect.
- **TX FIFO**
  - Push is accepted when not full, or when full and a pop occurs in the same cycle.
  - A rejected push sets OVF and drops the byte.
  - Pop occurs when tx_valid & tx_ready.
  - tx_valid = !EMPTY; tx_data = head byte. tx_data is 0 when empty.
- **Simultaneous events**
  - If MATCH sets and a write-1-to-clear to MATCH happen in the same cycle, the set wins.
  - If OVF sets and a write-1-to-clear to OVF happen in the same cycle, the set wins.

## Timing
- **Reads**
  - Zero latency: MemRdata is a combinational function of Memaddr and current state.
  - The CPU captures it at the next rising edge.
- **Writes** commit on the rising edge where Memwrite=1.
  - A read of the address being written in that cycle returns the old value.
  - CYCLE read returns the pre-increment value of that cycle.
- **TXSTAT** reflects the state before this cycle's push or pop.
- **Reset**
  - Values after reset: CYCLE=0, TCMP=0xFFFFFFFF, MATCH=0, LED=0, OVF=0.
  - The FIFO is emptied: tx_valid=0, tx_data=0, TXSTAT=0x00000002.
  - RAM contents are not reset.
  - Reset asserted mid-transfer discards queued bytes. A concurrent pop has no further effect.
- **MATCH detection**: registered; it is visible on reads one cycle after the cycle with CYCLE==TCMP.

## Configuration
- The macro is DMEM_TXFIFO_EN.
- **Defined**: TX FIFO, TXDATA, TXSTAT and the tx_* handshake are implemented as described above.
- **Undefined**:
  - No FIFO storage is built.
  - TXDATA writes are ignored.
  - TXSTAT reads 0.
  - tx_valid=0 and tx_data=0 constantly; tx_ready is ignored.

## Structure
- Package rv32i_dmem_pkg holds:
  - region match constants (RAM_TAG=4'h1, IO_BASE=24'hFFFF00);
  - register offsets (OFF_CYCLE, OFF_TCMP, OFF_TSTAT, OFF_LED, OFF_TXDATA, OFF_TXSTAT);
  - the TXSTAT bit positions.
- Sub-module dmem_txfifo is a synchronous FIFO:
  - ports: push, push_data, pop, head, full, empty, count;
  - read/write pointers are log2(DEPTH) bits wide with a separate count of log2(DEPTH)+1 bits.
- The top level holds the address decode, the RAM array, CYCLE/TCMP/TSTAT/LED, and the read mux.

## Test plan
- **RAM write/read**: write 0xDEADBEEF to 0x10000010, then read 0x10000010 → 0xDEADBEEF. Read 0x10000014 (never written) → no corruption of 0x10000010.
- **Unmapped address**: write 0x12345678 to 0x20000000, read it back → 0x00000000. RAM and IO are unchanged.
- **Cycle counter and timer**:
  - Read CYCLE on 1st cycle after reset → 0.
  - Write TCMP=100 → TSTAT reads 1 from cycle 101 on.
  - Write TSTAT=1 → MATCH clears.
- **LED register**: write 0xFFFFFFA5 to 0xFFFF000C → led=8'hA5; read back → 0x000000A5.
- **FIFO fill and overflow**:
  - Hold tx_ready=0 and push 9 bytes 0x41..0x49 (depth 8).
  - TXSTAT → count 8, FULL=1, OVF=1.
  - Drain with tx_ready=1 → 0x41..0x48 out in order, then tx_valid=0, TXSTAT=0x00000006.
- **Push while full with same-cycle pop**:
  - Start full with tx_ready=1; push 0x5A in the same cycle → accepted, OVF stays 0, count stays 8.
  - Assert reset mid-drain → tx_valid=0 on the next cycle.

Source files
------------

// File: rtl/rv32i_dmem_pkg.sv
// Shared constants for the RV32I data-memory responder: region tags, IO register
// offsets, TXSTAT bit layout and the IO offset decoder.
package rv32i_dmem_pkg;

    localparam logic [3:0]  RAM_TAG = 4'h1;
    localparam logic [23:0] IO_BASE = 24'hFFFF00;

    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_TCMP   = 8'h04;
    localparam logic [7:0] OFF_TSTAT  = 8'h08;
    localparam logic [7:0] OFF_LED    = 8'h0C;
    localparam logic [7:0] OFF_TXDATA = 8'h10;
    localparam logic [7:0] OFF_TXSTAT = 8'h14;

    localparam int TSTAT_MATCH = 0;
    localparam int TXS_FULL    = 0;
    localparam int TXS_EMPTY   = 1;
    localparam int TXS_OVF     = 2;
    localparam int TXS_CNT_LSB = 8;
    localparam int TXS_CNT_W   = 8;

    typedef enum logic [2:0] {
        IO_CYCLE,
        IO_TCMP,
        IO_TSTAT,
        IO_LED,
        IO_TXDATA,
        IO_TXSTAT,
        IO_NONE
    } io_reg_e;

    // Byte-lane bits are ignored, so decode on the word offset only.
    function automatic io_reg_e io_decode(input logic [5:0] word_off);
        io_reg_e r;
        case (word_off)
            OFF_CYCLE[7:2]:  r = IO_CYCLE;
            OFF_TCMP[7:2]:   r = IO_TCMP;
            OFF_TSTAT[7:2]:  r = IO_TSTAT;
            OFF_LED[7:2]:    r = IO_LED;
            OFF_TXDATA[7:2]: r = IO_TXDATA;
            OFF_TXSTAT[7:2]: r = IO_TXSTAT;
            default:         r = IO_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// CPU data-port bus plus the TX byte stream of the data-memory responder.
interface rv32i_dmem_responder_if;

    logic        Memwrite;
    logic [31:0] Memaddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output Memwrite, Memaddr, MemWdata, tx_ready,
        input  MemRdata, tx_valid, tx_data
    );

    modport slave (
        input  Memwrite, Memaddr, MemWdata, tx_ready,
        output MemRdata, tx_valid, tx_data
    );

endinterface

// File: rtl/rv32i_dmem_responder_txfifo.sv
// Synchronous byte FIFO for the TX path; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module dmem_txfifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is never reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-side memory responder: word RAM plus IO bank (CYCLE, TCMP, TSTAT, LED, TX FIFO).
// The TX FIFO, TXDATA/TXSTAT and the tx handshake exist only when DMEM_TXFIFO_EN is defined.
module rv32i_dmem_responder
    import rv32i_dmem_pkg::*;
#(
    parameter int RAM_WORDS    = 1024,
    parameter int LED_WIDTH    = 8,
    parameter int TXFIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rv32i_dmem_responder_if.slave bus,
    output logic [LED_WIDTH-1:0]  led
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(TXFIFO_DEPTH) + 1;

    logic              ram_sel;
    logic              io_sel;
    io_reg_e           io_reg;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [RAM_WORDS];
    logic [31:0]       cycle_q;
    logic [31:0]       tcmp_q;
    logic              match_q;
    logic              match_hit;
    logic              match_clr;
    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]       txstat;
    logic [31:0]       rdata;
    logic              unused_lsbs;

    assign ram_sel     = bus.Memaddr[31:28] == RAM_TAG;
    assign io_sel      = bus.Memaddr[31:8] == IO_BASE;
    assign ram_idx     = bus.Memaddr[RAM_AW+1:2];
    assign io_reg      = io_sel ? io_decode(bus.Memaddr[7:2]) : IO_NONE;
    assign unused_lsbs = ^bus.Memaddr[1:0];

    always_ff @(posedge clk) begin
        if (bus.Memwrite && ram_sel) ram[ram_idx] <= bus.MemWdata;
    end

    assign match_hit = cycle_q == tcmp_q;
    assign match_clr = bus.Memwrite && (io_reg == IO_TSTAT) && bus.MemWdata[TSTAT_MATCH];

    // A MATCH set outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            tcmp_q  <= '1;
            match_q <= 1'b0;
            led_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (bus.Memwrite && io_reg == IO_TCMP) tcmp_q <= bus.MemWdata;
            if (match_hit)      match_q <= 1'b1;
            else if (match_clr) match_q <= 1'b0;
            if (bus.Memwrite && io_reg == IO_LED) led_q <= bus.MemWdata[LED_WIDTH-1:0];
        end
    end

    assign led = led_q;

`ifdef DMEM_TXFIFO_EN
    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [CNT_W-1:0] tx_count;
    logic [7:0]       tx_head;
    logic             ovf_q;
    logic             ovf_clr;

    assign tx_push = bus.Memwrite && (io_reg == IO_TXDATA);
    assign tx_pop  = bus.tx_valid && bus.tx_ready;
    assign ovf_clr = bus.Memwrite && (io_reg == IO_TXSTAT) && bus.MemWdata[TXS_OVF];

    dmem_txfifo #(
        .DEPTH (TXFIFO_DEPTH),
        .W     (8)
    ) u_txfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (bus.MemWdata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_head;

    // Overflow only when full and no pop frees a slot; set outranks clear.
    always_ff @(posedge clk) begin
        if (reset)                                 ovf_q <= 1'b0;
        else if (tx_push && tx_full && !tx_pop)    ovf_q <= 1'b1;
        else if (ovf_clr)                          ovf_q <= 1'b0;
    end

    always_comb begin
        txstat                                = '0;
        txstat[TXS_FULL]                      = tx_full;
        txstat[TXS_EMPTY]                     = tx_empty;
        txstat[TXS_OVF]                       = ovf_q;
        txstat[TXS_CNT_LSB +: TXS_CNT_W]      = 8'(tx_count);
    end
`else
    logic unused_tx_ready;

    assign bus.tx_valid    = 1'b0;
    assign bus.tx_data     = 8'h00;
    assign txstat          = '0;
    assign unused_tx_ready = bus.tx_ready;
`endif

    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = ram[ram_idx];
        end else begin
            case (io_reg)
                IO_CYCLE:  rdata = cycle_q;
                IO_TCMP:   rdata = tcmp_q;
                IO_TSTAT:  rdata[TSTAT_MATCH] = match_q;
                IO_LED:    rdata[LED_WIDTH-1:0] = led_q;
                IO_TXSTAT: rdata = txstat;
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.MemRdata = rdata;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Scoreboard bench for rv32i_dmem_responder: directed scenarios then random traffic,
// checked against a queue/array reference model of the memory map.
module tb_rv32i_dmem_responder;

    localparam int RAM_WORDS = 1024;
    localparam int LED_WIDTH = 8;
    localparam int DEPTH     = 8;
`ifdef DMEM_TXFIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
    localparam logic [31:0] A_TSTAT  = 32'hFFFF_0008;
    localparam logic [31:0] A_LED    = 32'hFFFF_000C;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF_0014;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [LED_WIDTH-1:0] led;

    rv32i_dmem_responder_if bus_if();

    rv32i_dmem_responder #(
        .RAM_WORDS    (RAM_WORDS),
        .LED_WIDTH    (LED_WIDTH),
        .TXFIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .led   (led)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]          m_ram [int unsigned];
    logic [31:0]          m_cyc;
    logic [31:0]          m_tcmp;
    logic                 m_match;
    logic                 m_ovf;
    logic [LED_WIDTH-1:0] m_led;
    logic [7:0]           m_fifo [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t              rd_q [$];
    logic [7:0]           tx_q [$];
    logic                 chk_rd = 1'b0;
    logic                 exp_txv = 1'b0;
    logic [LED_WIDTH-1:0] exp_led = '0;
    bit                   armed = 1'b0;
    int                   checks = 0;
    int                   failures = 0;
    rd_exp_t              mon_e;
    logic [7:0]           mon_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v;
        int unsigned idx;
        v = '0;
        idx = (a >> 2) % RAM_WORDS;
        if (a[31:28] == 4'h1) begin
            v = m_ram.exists(idx) ? m_ram[idx] : 'x;
        end else if (a[31:8] == 24'hFFFF00) begin
            case (a[7:0] & 8'hFC)
                8'h00: v = m_cyc;
                8'h04: v = m_tcmp;
                8'h08: v = {31'b0, m_match};
                8'h0C: v = 32'(m_led);
                8'h14: if (FIFO_EN) begin
                    v[15:8] = 8'(m_fifo.size());
                    v[2]    = m_ovf;
                    v[1]    = m_fifo.size() == 0;
                    v[0]    = m_fifo.size() == DEPTH;
                end
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // One bus cycle: drive, record expectations from the pre-edge model, then advance the model.
    task automatic cycle_t(input bit rst, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit rdy, input bit chk);
        bit          io;
        bit          pop;
        bit          full_pre;
        bit          push;
        bit          ovf_set;
        bit          match_set;
        logic [7:0]  off;
        rd_exp_t     e;
        int unsigned idx;
        @(posedge clk);
        #1;
        reset           = rst;
        bus_if.Memwrite = we;
        bus_if.Memaddr  = addr;
        bus_if.MemWdata = wdata;
        bus_if.tx_ready = rdy;
        chk_rd          = chk && !rst;
        if (rst) begin
            armed   = 1'b1;
            m_cyc   = '0;
            m_tcmp  = '1;
            m_match = 1'b0;
            m_led   = '0;
            m_ovf   = 1'b0;
            m_fifo.delete();
            return;
        end
        exp_led = m_led;
        exp_txv = m_fifo.size() != 0;
        if (chk_rd) begin
            e.addr = addr;
            e.data = model_read(addr);
            rd_q.push_back(e);
        end
        io       = addr[31:8] == 24'hFFFF00;
        off      = addr[7:0] & 8'hFC;
        full_pre = m_fifo.size() == DEPTH;
        pop      = rdy && (m_fifo.size() != 0);
        if (pop) tx_q.push_back(m_fifo.pop_front());
        push    = FIFO_EN && we && io && (off == 8'h10);
        ovf_set = push && full_pre && !pop;
        if (push && !ovf_set) m_fifo.push_back(wdata[7:0]);
        match_set = m_cyc == m_tcmp;
        if (we && io) begin
            case (off)
                8'h04: m_tcmp = wdata;
                8'h08: if (wdata[0]) m_match = 1'b0;
                8'h0C: m_led = wdata[LED_WIDTH-1:0];
                8'h14: if (FIFO_EN && wdata[2]) m_ovf = 1'b0;
                default: ;
            endcase
        end
        if (match_set) m_match = 1'b1;
        if (ovf_set)   m_ovf   = 1'b1;
        idx = (addr >> 2) % RAM_WORDS;
        if (we && addr[31:28] == 4'h1) m_ram[idx] = wdata;
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit rdy = 1'b0);
        cycle_t(1'b0, 1'b1, a, d, rdy, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input bit rdy = 1'b0);
        cycle_t(1'b0, 1'b0, a, 32'h0, rdy, 1'b1);
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a read or a TX transfer.
    always @(negedge clk) begin
        if (armed && !reset) begin
            if (chk_rd) begin
                if (rd_q.size() == 0) begin
                    check("rd_scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    mon_e = rd_q.pop_front();
                    check($sformatf("rdata@%h", mon_e.addr), bus_if.MemRdata, mon_e.data);
                end
            end
            check("led", 32'(led), 32'(exp_led));
            check("tx_valid", 32'(bus_if.tx_valid), 32'(exp_txv));
            if (bus_if.tx_valid && bus_if.tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("tx_scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    mon_b = tx_q.pop_front();
                    check("tx_data", 32'(bus_if.tx_data), 32'(mon_b));
                end
            end else if (!bus_if.tx_valid) begin
                check("tx_data_idle", 32'(bus_if.tx_data), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  nib;
        int          k;
        bit          we;
        bit          rdy;

        reset           = 1'b1;
        bus_if.Memwrite = 1'b0;
        bus_if.Memaddr  = '0;
        bus_if.MemWdata = '0;
        bus_if.tx_ready = 1'b0;

        cycle_t(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle_t(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset values
        rd(A_CYCLE);
        rd(A_TCMP);
        rd(A_TSTAT);
        rd(A_LED);
        rd(A_TXSTAT);
        rd(A_TXDATA);

        // RAM write/read, untouched neighbour
        wr(32'h1000_0010, 32'hDEAD_BEEF);
        cycle_t(1'b0, 1'b0, 32'h1000_0014, 32'h0, 1'b0, 1'b0);
        rd(32'h1000_0010);

        // Unmapped access
        wr(32'h2000_0000, 32'h1234_5678);
        rd(32'h2000_0000);
        rd(32'h1000_0010);
        rd(A_LED);
        rd(A_TCMP);

        // LED register
        wr(A_LED, 32'hFFFF_FFA5);
        rd(A_LED);

        // Timer compare from a fresh reset
        cycle_t(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        wr(A_TCMP, 32'd100);
        for (int i = 0; i < 104; i++) rd(A_TSTAT);
        rd(A_CYCLE);
        wr(A_TSTAT, 32'd1);
        rd(A_TSTAT);

        // FIFO fill with overflow, then drain
        for (int b = 8'h41; b <= 8'h49; b++) wr(A_TXDATA, 32'(b), 1'b0);
        rd(A_TXSTAT);
        for (int i = 0; i < 10; i++) rd(A_TXSTAT, 1'b1);
        rd(A_TXSTAT);
        wr(A_TXSTAT, 32'h4);
        rd(A_TXSTAT);

        // Push while full with a same-cycle pop, then reset mid-drain
        for (int b = 0; b < DEPTH; b++) wr(A_TXDATA, 32'(8'h60 + b), 1'b0);
        wr(A_TXDATA, 32'h5A, 1'b1);
        rd(A_TXSTAT);
        for (int i = 0; i < 3; i++) rd(A_TXSTAT, 1'b1);
        cycle_t(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rd(A_TXSTAT, 1'b1);
        rd(A_CYCLE);

        // Random traffic over a small aliased RAM window and the IO bank
        for (int i = 0; i < 16; i++) wr(32'h1000_0000 | (32'(i) << 2), $urandom);
        for (int n = 0; n < 500; n++) begin
            k   = $urandom_range(0, 3);
            we  = $urandom_range(0, 1) == 1;
            rdy = $urandom_range(0, 2) != 0;
            d   = $urandom;
            case (k)
                0: a = {4'h1, 16'($urandom), 12'({$urandom_range(0, 15), 2'b00})};
                1: begin
                    a = 32'hFFFF_0000 | 32'({$urandom_range(0, 7), 2'b00});
                    if (a == A_TCMP && $urandom_range(0, 1) == 1) d = m_cyc + 32'($urandom_range(1, 6));
                end
                2: a = A_TXDATA;
                default: begin
                    nib = 4'($urandom_range(2, 14));
                    a   = {nib, 28'($urandom)};
                end
            endcase
            if ($urandom_range(0, 149) == 0) cycle_t(1'b1, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
            else                             cycle_t(1'b0, we, a, d, rdy, 1'b1);
        end

        cycle_t(1'b0, 1'b0, 32'h3000_0000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
